oled_source_arbiter: RTL and testbench



---
 rtl/oled_source_arbiter_if.sv | 33 +++
 rtl/oled_source_arbiter.sv | 158 +++++++++++++++
 tb/tb_oled_source_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/oled_source_arbiter_if.sv
// Bundle between the student feature blocks, the OLED driver and the source arbiter.
// The master side drives switches, frame timing and candidate sources; the slave side returns the muxed outputs.
interface oled_source_arbiter_if;
    logic [15:0] sw;
    logic        frame_begin;
    logic [15:0] oled_data_init;
    logic [15:0] oled_data_A;
    logic [15:0] oled_data_B;
    logic [15:0] oled_data_C;
    logic [15:0] oled_data_D;
    logic [15:0] led_A;
    logic [15:0] led_B;
    logic [15:0] led_C;
    logic [15:0] led_D;
    logic [15:0] led;
    logic [15:0] oled_data;
    logic [2:0]  active_sel;
    logic        switching;

    modport master (
        output sw, frame_begin,
        output oled_data_init, oled_data_A, oled_data_B, oled_data_C, oled_data_D,
        output led_A, led_B, led_C, led_D,
        input  led, oled_data, active_sel, switching
    );

    modport slave (
        input  sw, frame_begin,
        input  oled_data_init, oled_data_A, oled_data_B, oled_data_C, oled_data_D,
        input  led_A, led_B, led_C, led_D,
        output led, oled_data, active_sel, switching
    );
endinterface

// File: rtl/oled_source_arbiter.sv
// Debounced password selection of the OLED/LED source, committed only on frame boundaries.
// Define OLED_ARB_BLANK_EN to insert BLANK_FRAMES black frames on every committed switch.
module oled_source_arbiter #(
    parameter logic [15:0] PW_A          = 16'h138D,
    parameter logic [15:0] PW_B          = 16'h2265,
    parameter logic [15:0] PW_C          = 16'hFFFF,
    parameter logic [15:0] PW_D          = 16'h8195,
    parameter int unsigned STABLE_CYCLES = 2_000_000,
    parameter int unsigned BLANK_FRAMES  = 2
) (
    input  logic                    clock_100mhz,
    input  logic                    reset_n,
    oled_source_arbiter_if.slave    bus
);

    localparam logic [31:0] STAB_MAX = 32'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        SHOW       = 2'd0,
        WAIT_FRAME = 2'd1
`ifdef OLED_ARB_BLANK_EN
        , BLANK    = 2'd2
`endif
    } state_t;

    function automatic logic [2:0] decode_pw(input logic [15:0] s);
        if (s == PW_A)      return 3'd1;
        else if (s == PW_B) return 3'd2;
        else if (s == PW_C) return 3'd3;
        else if (s == PW_D) return 3'd4;
        else                return 3'd0;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == STAB_MAX) ? c : c + 32'd1;
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  cand, cand_q;
    logic [31:0] stab_cnt;
    logic        frame_begin_q;
    logic [2:0]  pending_sel, pending_d;
    logic [2:0]  active_q, active_d;
    logic [15:0] led_q, oled_q;
    logic        switching_q;
    logic        stable, fb_edge, blank_now;
    logic [15:0] src_led, src_oled;

`ifdef OLED_ARB_BLANK_EN
    localparam int BW = $clog2(BLANK_FRAMES + 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_FRAMES - 1);
    logic [BW-1:0] blank_cnt, blank_d;
    assign blank_now = (state_q == BLANK);
`else
    assign blank_now = 1'b0;
`endif

    assign cand    = decode_pw(bus.sw);
    assign stable  = (stab_cnt == STAB_MAX) && (cand == cand_q);
    assign fb_edge = bus.frame_begin & ~frame_begin_q;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_sel;
        active_d  = active_q;
`ifdef OLED_ARB_BLANK_EN
        blank_d   = blank_cnt;
`endif
        case (state_q)
            SHOW: begin
                if (stable && (cand_q != active_q)) begin
                    pending_d = cand_q;
                    state_d   = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                // A changed selection wins over a coincident frame edge
                if (cand != pending_sel) begin
                    state_d = SHOW;
                end else if (fb_edge) begin
                    active_d = pending_sel;
`ifdef OLED_ARB_BLANK_EN
                    state_d  = BLANK;
                    blank_d  = '0;
`else
                    state_d  = SHOW;
`endif
                end
            end
`ifdef OLED_ARB_BLANK_EN
            BLANK: begin
                if (fb_edge) begin
                    if (blank_cnt == BLANK_LAST) begin
                        state_d = SHOW;
                        blank_d = '0;
                    end else begin
                        blank_d = blank_cnt + 1'b1;
                    end
                end
            end
`endif
            default: state_d = SHOW;
        endcase
    end

    always_comb begin
        src_led  = 16'h0000;
        src_oled = bus.oled_data_init;
        case (active_q)
            3'd1: begin src_led = bus.led_A; src_oled = bus.oled_data_A; end
            3'd2: begin src_led = bus.led_B; src_oled = bus.oled_data_B; end
            3'd3: begin src_led = bus.led_C; src_oled = bus.oled_data_C; end
            3'd4: begin src_led = bus.led_D; src_oled = bus.oled_data_D; end
            default: ;
        endcase
    end

    always_ff @(posedge clock_100mhz) begin
        if (!reset_n) begin
            state_q       <= SHOW;
            cand_q        <= 3'd0;
            stab_cnt      <= 32'd0;
            frame_begin_q <= 1'b0;
            pending_sel   <= 3'd0;
            active_q      <= 3'd0;
            led_q         <= 16'h0000;
            oled_q        <= 16'h0000;
            switching_q   <= 1'b0;
`ifdef OLED_ARB_BLANK_EN
            blank_cnt     <= '0;
`endif
        end else begin
            if (cand != cand_q) begin
                cand_q   <= cand;
                stab_cnt <= 32'd0;
            end else begin
                stab_cnt <= sat_inc(stab_cnt);
            end
            frame_begin_q <= bus.frame_begin;
            state_q       <= state_d;
            pending_sel   <= pending_d;
            active_q      <= active_d;
            switching_q   <= (state_d != SHOW);
`ifdef OLED_ARB_BLANK_EN
            blank_cnt     <= blank_d;
`endif
            // Output register stage: one cycle from source inputs
            led_q  <= blank_now ? 16'h0000 : src_led;
            oled_q <= blank_now ? 16'h0000 : src_oled;
        end
    end

    assign bus.led        = led_q;
    assign bus.oled_data  = oled_q;
    assign bus.active_sel = active_q;
    assign bus.switching  = switching_q;

endmodule

// File: tb/tb_oled_source_arbiter.sv
// Randomized bench for oled_source_arbiter against a run-length/frame-counting reference model.
// Builds with or without OLED_ARB_BLANK_EN; the model follows the same macro.
module tb_oled_source_arbiter;
    localparam logic [15:0] PW_A = 16'h138D;
    localparam logic [15:0] PW_B = 16'h2265;
    localparam logic [15:0] PW_C = 16'hFFFF;
    localparam logic [15:0] PW_D = 16'h8195;
    localparam int STAB = 4;
    localparam int BF   = 2;
    localparam int FRAME_PERIOD = 100;
`ifdef OLED_ARB_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    logic clock_100mhz = 1'b0;
    logic reset_n;
    always #5 clock_100mhz = ~clock_100mhz;

    oled_source_arbiter_if bus();

    oled_source_arbiter #(
        .PW_A(PW_A), .PW_B(PW_B), .PW_C(PW_C), .PW_D(PW_D),
        .STABLE_CYCLES(STAB), .BLANK_FRAMES(BF)
    ) dut (
        .clock_100mhz(clock_100mhz),
        .reset_n(reset_n),
        .bus(bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [15:0] src_oled [0:4];
    logic [15:0] src_led  [0:4];

    // Reference model: selection age as a run length, modes 0=show 1=wait 2=black
    int          m_last, m_run, m_mode, m_pend, m_act, m_bcnt;
    bit          m_fbq, m_swi;
    logic [15:0] m_led, m_oled;

    int act_hist[$];
    int last_act;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int decode(input logic [15:0] s);
        if (s == PW_A) return 1;
        if (s == PW_B) return 2;
        if (s == PW_C) return 3;
        if (s == PW_D) return 4;
        return 0;
    endfunction

    task automatic model_step();
        int c, cur_run;
        bit stable, fb;
        if (!reset_n) begin
            m_last = 0; m_run = 1; m_mode = 0; m_pend = 0; m_act = 0; m_bcnt = 0;
            m_fbq = 1'b0; m_swi = 1'b0; m_led = 16'h0; m_oled = 16'h0;
            return;
        end
        c       = decode(bus.sw);
        cur_run = (c == m_last) ? m_run + 1 : 1;
        stable  = (cur_run > STAB);
        fb      = bus.frame_begin && !m_fbq;
        if (m_mode == 2) begin
            m_led = 16'h0; m_oled = 16'h0;
        end else begin
            m_led = src_led[m_act]; m_oled = src_oled[m_act];
        end
        case (m_mode)
            0: if (stable && c != m_act) begin m_pend = c; m_mode = 1; end
            1: begin
                if (c != m_pend) m_mode = 0;
                else if (fb) begin
                    m_act = m_pend; m_bcnt = 0;
                    m_mode = BLANK_EN ? 2 : 0;
                end
            end
            default: if (fb) begin
                m_bcnt++;
                if (m_bcnt == BF) m_mode = 0;
            end
        endcase
        m_swi  = (m_mode != 0);
        m_last = c;
        m_run  = (cur_run > 1000) ? 1000 : cur_run;
        m_fbq  = bus.frame_begin;
    endtask

    task automatic step();
        bus.frame_begin = ((cyc % FRAME_PERIOD) < 8);
        for (int i = 0; i < 5; i++) src_oled[i] = 16'($urandom());
        for (int i = 1; i < 5; i++) src_led[i]  = 16'($urandom());
        bus.oled_data_init = src_oled[0];
        bus.oled_data_A = src_oled[1]; bus.oled_data_B = src_oled[2];
        bus.oled_data_C = src_oled[3]; bus.oled_data_D = src_oled[4];
        bus.led_A = src_led[1]; bus.led_B = src_led[2];
        bus.led_C = src_led[3]; bus.led_D = src_led[4];
        model_step();
        @(posedge clock_100mhz);
        #1;
        cyc++;
        check("led", bus.led, m_led);
        check("oled_data", bus.oled_data, m_oled);
        check("active_sel", bus.active_sel, m_act);
        check("switching", bus.switching, m_swi);
        if (int'(bus.active_sel) != last_act) begin
            act_hist.push_back(int'(bus.active_sel));
            last_act = int'(bus.active_sel);
        end
    endtask

    task automatic align(input int phase);
        while ((cyc % FRAME_PERIOD) != phase) step();
    endtask

    initial begin
        src_led[0] = 16'h0000;
        last_act   = 0;
        reset_n    = 1'b0;
        bus.sw     = PW_B;

        // Reset holds everything at zero even with a valid password present
        repeat (3) step();
        check("rst_led", bus.led, 16'h0);
        check("rst_oled", bus.oled_data, 16'h0);
        check("rst_active", bus.active_sel, 3'd0);
        check("rst_switching", bus.switching, 1'b0);
        reset_n = 1'b1;
        bus.sw  = 16'h0;

        // Bounce between PW_D and nothing every 3 cycles
        align(20);
        for (int i = 0; i < 50; i++) begin
            bus.sw = (((i / 3) % 2) == 0) ? PW_D : 16'h0;
            step();
        end
        check("bounce_active", bus.active_sel, 3'd0);
        check("bounce_switching", bus.switching, 1'b0);

        // Abort: PW_B becomes stable, then withdrawn before the frame edge
        bus.sw = 16'h0;
        align(20);
        bus.sw = PW_B;
        repeat (5) step();
        check("abort_pending", bus.switching, 1'b1);
        bus.sw = 16'h0;
        step();
        check("abort_switching", bus.switching, 1'b0);
        repeat (150) step();
        check("abort_active", bus.active_sel, 3'd0);

        // Clean switch to A, then B requested while A is still blanking
        align(20);
        bus.sw = PW_A;
        repeat (4) step();
        check("rise_early", bus.switching, 1'b0);
        step();
        check("rise_at_5", bus.switching, 1'b1);
        repeat (80) step();
        check("commit_A", bus.active_sel, 3'd1);
        bus.sw = PW_B;
        repeat (500) step();
        check("commit_B", bus.active_sel, 3'd2);
        check("hist_len", act_hist.size(), 2);
        check("hist_first", act_hist[0], 1);
        check("hist_second", act_hist[1], 2);

        // Randomized password traffic, including junk values
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 5))
                0: bus.sw = PW_A;
                1: bus.sw = PW_B;
                2: bus.sw = PW_C;
                3: bus.sw = PW_D;
                4: bus.sw = 16'h0;
                default: bus.sw = 16'($urandom());
            endcase
            repeat ($urandom_range(1, 40)) step();
        end

        // Settle on init, then reset in the middle of a PW_D switch
        bus.sw = 16'h0;
        repeat (400) step();
        align(20);
        bus.sw = PW_D;
        repeat (6) step();
        check("pre_reset_wait", bus.switching, 1'b1);
        reset_n = 1'b0;
        step();
        check("midrst_active", bus.active_sel, 3'd0);
        check("midrst_switching", bus.switching, 1'b0);
        reset_n = 1'b1;
        repeat (300) step();
        check("commit_D", bus.active_sel, 3'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
